// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer/flag controller for a dual-clock FIFO: synchronises the gray write pointer,
// tracks the read pointer, and produces raddr, empty, rd_count and underflow. Optional: ASYNC_FIFO_RD_ALMOST_EMPTY_EN.
module async_fifo_rd_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
`ifdef ASYNC_FIFO_RD_ALMOST_EMPTY_EN
    ,
    parameter int ALMOST_EMPTY_THRESH = 2
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wptr_gray_async,
    input  logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rd_fire,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
`ifdef ASYNC_FIFO_RD_ALMOST_EMPTY_EN
    ,
    output logic                  almost_empty
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wsync_q [SYNC_STAGES];
    logic [PW-1:0] wsync;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_next;
    logic [PW-1:0] rptr_gray_next;
    logic [PW-1:0] count_next;

    // Write-pointer synchroniser: a plain flop chain, no logic between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= '0;
            end
        end else begin
            wsync_q[0] <= wptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= wsync_q[i-1];
            end
        end
    end

    assign wsync = wsync_q[SYNC_STAGES-1];
    assign wbin  = gray2bin(wsync);

    assign rd_fire        = rd_en & ~empty;
    assign rptr_next      = rptr_bin + {{ADDR_WIDTH{1'b0}}, rd_fire};
    assign rptr_gray_next = bin2gray(rptr_next);
    // A write seen in the same cycle as a read is folded in together with the advanced read pointer.
    assign count_next     = wbin - rptr_next;
    assign raddr          = rptr_bin[ADDR_WIDTH-1:0];

    // Read pointer, flags and fill count all register off rptr_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            empty     <= 1'b1;
            rd_count  <= '0;
            underflow <= 1'b0;
        end else begin
            rptr_bin  <= rptr_next;
            rptr_gray <= rptr_gray_next;
            empty     <= (rptr_gray_next == wsync);
            rd_count  <= count_next;
            underflow <= rd_en & empty;
        end
    end

`ifdef ASYNC_FIFO_RD_ALMOST_EMPTY_EN
    localparam logic [31:0]   AE_THRESH_32 = ALMOST_EMPTY_THRESH;
    localparam logic [PW-1:0] AE_THRESH    = AE_THRESH_32[PW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_empty <= 1'b1;
        end else begin
            almost_empty <= (count_next <= AE_THRESH);
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2): vector table plus corner sequences.
module tb_async_fifo_rd_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] wptr_gray_async;
    logic       rd_en;
    logic [3:0] raddr;
    logic       rd_fire;
    logic [4:0] rptr_gray;
    logic       empty;
    logic [4:0] rd_count;
    logic       underflow;
`ifdef ASYNC_FIFO_RD_ALMOST_EMPTY_EN
    logic       almost_empty;
`endif

    int total = 0;
    int bad   = 0;

    async_fifo_rd_ctrl #(
        .ADDR_WIDTH (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wptr_gray_async(wptr_gray_async),
        .rd_en          (rd_en),
        .raddr          (raddr),
        .rd_fire        (rd_fire),
        .rptr_gray      (rptr_gray),
        .empty          (empty),
        .rd_count       (rd_count),
        .underflow      (underflow)
`ifdef ASYNC_FIFO_RD_ALMOST_EMPTY_EN
        ,
        .almost_empty   (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rd_en;
        logic [4:0] w;
        logic       e;
        logic [4:0] c;
        logic [3:0] ra;
        logic [4:0] g;
        logic       uf;
        logic       fire;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] gr(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic do_reset();
        rd_en           = 1'b0;
        wptr_gray_async = 5'd0;
        rst_n           = 1'b0;
        tick();
        tick();
        check("rst empty", 32'(empty), 32'd1);
        check("rst count", 32'(rd_count), 32'd0);
        check("rst raddr", 32'(raddr), 32'd0);
        check("rst gray", 32'(rptr_gray), 32'd0);
        check("rst underflow", 32'(underflow), 32'd0);
`ifdef ASYNC_FIFO_RD_ALMOST_EMPTY_EN
        check("rst almost_empty", 32'(almost_empty), 32'd1);
`endif
        #2 rst_n = 1'b1;
    endtask

    initial begin
        //            rd_en  w         e     c      raddr  gray      uf    fire
        tbl[0] = '{1'b1, 5'b00000, 1'b1, 5'd0, 4'd0, 5'b00000, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 5'b00000, 1'b1, 5'd0, 4'd0, 5'b00000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 5'b00010, 1'b1, 5'd0, 4'd0, 5'b00000, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 5'b00010, 1'b1, 5'd0, 4'd0, 5'b00000, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'b00010, 1'b0, 5'd3, 4'd0, 5'b00000, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 5'b00010, 1'b0, 5'd2, 4'd1, 5'b00001, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 5'b00010, 1'b0, 5'd1, 4'd2, 5'b00011, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 5'b00010, 1'b1, 5'd0, 4'd3, 5'b00010, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 5'b00010, 1'b1, 5'd0, 4'd3, 5'b00010, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 5'b00010, 1'b1, 5'd0, 4'd3, 5'b00010, 1'b0, 1'b0};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            rd_en           = tbl[i].rd_en;
            wptr_gray_async = tbl[i].w;
            tick();
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].e));
            check($sformatf("vec%0d count", i), 32'(rd_count), 32'(tbl[i].c));
            check($sformatf("vec%0d raddr", i), 32'(raddr), 32'(tbl[i].ra));
            check($sformatf("vec%0d gray", i), 32'(rptr_gray), 32'(tbl[i].g));
            check($sformatf("vec%0d underflow", i), 32'(underflow), 32'(tbl[i].uf));
            check($sformatf("vec%0d rd_fire", i), 32'(rd_fire), 32'(tbl[i].fire));
        end

        // Full, then drain 16 entries across the address wrap.
        do_reset();
        for (int b = 1; b <= 16; b++) begin
            wptr_gray_async = gr(b);
            tick();
        end
        tick();
        tick();
        tick();
        check("full count", 32'(rd_count), 32'd16);
        check("full empty", 32'(empty), 32'd0);
        rd_en = 1'b1;
        tick();
        check("full-1 count", 32'(rd_count), 32'd15);
        check("full-1 raddr", 32'(raddr), 32'd1);
        for (int i = 2; i <= 16; i++) begin
            tick();
            check($sformatf("wrap raddr%0d", i), 32'(raddr), 32'(i % 16));
        end
        check("wrap gray", 32'(rptr_gray), 32'b11000);
        check("wrap empty", 32'(empty), 32'd1);
        check("wrap count", 32'(rd_count), 32'd0);
        check("wrap rd_fire", 32'(rd_fire), 32'd0);
        rd_en = 1'b0;
        wptr_gray_async = 5'b11001;
        tick();
        tick();
        check("w17 latency count", 32'(rd_count), 32'd0);
        check("w17 latency empty", 32'(empty), 32'd1);
        tick();
        check("w17 count", 32'(rd_count), 32'd1);
        check("w17 empty", 32'(empty), 32'd0);

        // Read and synchronised write land in the same cycle.
        wptr_gray_async = 5'b11011;
        tick();
        tick();
        tick();
        check("simul pre count", 32'(rd_count), 32'd2);
        wptr_gray_async = 5'b11010;
        tick();
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("simul count", 32'(rd_count), 32'd2);
        check("simul raddr", 32'(raddr), 32'd1);
        check("simul gray", 32'(rptr_gray), 32'b11001);

        // Asynchronous reset in the middle of operation.
        do_reset();
        for (int b = 1; b <= 5; b++) begin
            wptr_gray_async = gr(b);
            tick();
        end
        tick();
        tick();
        check("mid pre count", 32'(rd_count), 32'd5);
        #1 rst_n = 1'b0;
        #1;
        check("mid async empty", 32'(empty), 32'd1);
        check("mid async count", 32'(rd_count), 32'd0);
        check("mid async raddr", 32'(raddr), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("mid relock empty", 32'(empty), 32'd1);
        tick();
        check("mid relock count", 32'(rd_count), 32'd5);
        check("mid relock empty2", 32'(empty), 32'd0);

`ifdef ASYNC_FIFO_RD_ALMOST_EMPTY_EN
        check("ae at 5", 32'(almost_empty), 32'd0);
        rd_en = 1'b1;
        tick();
        tick();
        check("ae count 3", 32'(rd_count), 32'd3);
        check("ae at 3", 32'(almost_empty), 32'd0);
        tick();
        rd_en = 1'b0;
        check("ae count 2", 32'(rd_count), 32'd2);
        check("ae at 2", 32'(almost_empty), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
- Read-side pointer/flag controller for the dual-clock FIFO: the reader counterpart of the write-side gray pointer logic.
- Synchronises the write-domain gray write pointer into the read clock domain and converts it to binary.
- Maintains the read pointer in binary and gray form, and produces the read address, the empty flag and the fill count.
- Exports a registered gray read pointer for the write domain's full-flag logic.

Parameters:
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2, flop stages in the write-pointer synchroniser; legal range 2..4.

Ports:
- clk  input  1  read-domain clock.
- rst_n  input  1  asynchronous, active-low reset.
- wptr_gray_async  input  ADDR_WIDTH+1  gray write pointer from the write domain; unsynchronised.
- rd_en  input  1  consumer read request.
- raddr  output  ADDR_WIDTH  RAM read address = rptr_bin[ADDR_WIDTH-1:0].
- rd_fire  output  1  rd_en & ~empty; the read is accepted this cycle.
- rptr_gray  output  ADDR_WIDTH+1  registered gray read pointer, exported to the write domain.
- empty  output  1  registered; 1 when no unread entries are visible.
- rd_count  output  ADDR_WIDTH+1  registered count of visible unread entries, 0..2**ADDR_WIDTH.
- underflow  output  1  one-cycle pulse when rd_en is high while empty is high.

Behaviour:
- Reset: clk and rst_n only, as decided (single clock; reset asynchronous, active-low). rst_n low immediately clears to zero: all synchroniser flops, rptr_bin, rptr_gray, raddr, rd_count and underflow. empty resets to 1.
- Synchroniser: SYNC_STAGES-flop chain on wptr_gray_async; wsync = last stage. No logic between stages.
- wbin = gray-to-binary(wsync): bit i = XOR of wsync bits i..MSB; combinational.
- rptr_next = rptr_bin + rd_fire, modulo 2**(ADDR_WIDTH+1).
- Each clk:
  - rptr_bin <= rptr_next
  - rptr_gray <= rptr_next ^ (rptr_next >> 1)
  - empty <= (gray(rptr_next) == wsync)
  - rd_count <= wbin - rptr_next, modulo 2**(ADDR_WIDTH+1)
- Invariant: rd_count == 0 iff empty == 1, every cycle.
- Latency: a write-pointer change at the input is reflected in empty and rd_count SYNC_STAGES+1 clk edges later.
- Read handshake:
  - rd_fire is combinational from the registered empty.
  - The RAM reads at raddr in the rd_fire cycle.
  - raddr advances on the following edge.
- Underflow: rd_en while empty → no pointer movement; underflow = 1 for that cycle only.
- Wrap-around: the pointer MSB toggles each pass through the RAM; raddr wraps from 2**ADDR_WIDTH-1 to 0 with no gap.
- Full visibility: wbin - rptr = 2**ADDR_WIDTH gives rd_count = 2**ADDR_WIDTH and empty = 0.
- Read and write-pointer update in the same cycle: both are applied (new wbin minus rptr_next); neither is dropped.
- The gray input changes at most one bit per write-domain update; the block does no multi-bit consistency checking.

Optional Feature:
- Macro: ASYNC_FIFO_RD_ALMOST_EMPTY_EN.
- Defined:
  - Adds parameter ALMOST_EMPTY_THRESH (default 2).
  - Adds output almost_empty (1 bit, registered): almost_empty <= ((wbin - rptr_next) <= ALMOST_EMPTY_THRESH).
  - almost_empty resets to 1.
- Undefined: the parameter and the port do not exist; all other behaviour is identical.

Test Plan (ADDR_WIDTH=4, SYNC_STAGES=2):
- Reset, then rd_en=1 with wptr_gray_async=0 → empty=1, rd_count=0, raddr=0, underflow=1 every cycle, rptr_gray stays 00000.
- wptr_gray_async=00010 (binary 3) → empty falls and rd_count=3 exactly 3 edges later. Then rd_en=1 for 3 cycles → raddr 0,1,2; empty=1, rd_count=0, rptr_gray=00010 after the third edge.
- Wrap: wptr stepped in gray to binary 16 (11000), read 16 entries → raddr 15 then 0; rptr_gray=11000; empty=1. A further write to binary 17 (11001) → rd_count=1.
- Full: rptr at 0, wptr_gray_async=11000 → rd_count=16, empty=0. Read one → rd_count=15.
- Simultaneous: rd_count=2, rd_fire in the same cycle the synchronised wptr advances by 1 → rd_count remains 2.
- Reset mid-operation: rd_count=5, assert rst_n=0 between edges → empty=1 and rd_count=0 immediately. After release with wptr unchanged, empty=0 and rd_count equals the wptr value after 3 edges.
- With ASYNC_FIFO_RD_ALMOST_EMPTY_EN defined and THRESH=2: rd_count 3→2 → almost_empty rises on the same edge as rd_count changes.
